// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   arb_state_e : arbiter FSM encoding (IDLE, SEND, WAIT_DONE)
//   NREQ_DEF    : default number of requesters
//   DBIT_DEF    : default data bits per byte
//   idx_w()     : index width for n items, never narrower than 1 bit
package uart_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned DBIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // $clog2 that stays usable as a vector width when n <= 1
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search.
// Ports:
//   req       : request vector, one bit per requester
//   ptr       : index of the previous owner; search starts at ptr+1 mod NREQ
//   winner    : index of the first requesting slot found from the start point
//   any_valid : high when at least one request bit is set
module rr_pick import uart_pkg::*; #(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]           req,
  input  logic [idx_w(NREQ)-1:0]    ptr,
  output logic [idx_w(NREQ)-1:0]    winner,
  output logic                      any_valid
);

  localparam int unsigned IW = idx_w(NREQ);

  logic [IW-1:0] start;
  int unsigned   idx;

  // Modulo increment done by compare so non-power-of-2 NREQ wraps correctly
  always_comb begin
    start = (32'(ptr) >= (NREQ - 1)) ? '0 : ptr + IW'(1);
  end

  // Rotated priority scan: first set bit at or after start wins
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(start) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!any_valid && req[IW'(idx)]) begin
        winner    = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of a single UART transmitter.
// A requester that wins keeps the transmitter until its byte marked "last"
// has been shifted out, or until it stalls for TIMEOUT cycles.
// Ports:
//   clk, reset    : clock and asynchronous active-high reset
//   req_valid     : per-requester byte available
//   req_data      : flattened bytes, requester i at [i*DBIT +: DBIT]
//   req_last      : byte is the final byte of the requester's packet
//   req_ready     : one-hot accept strobe, combinational from state
//   tx_start      : one-cycle launch pulse for the transmitter
//   tx_din        : byte for the transmitter, held until tx_done_tick
//   tx_done_tick  : transmitter finished the current byte
//   grant_id      : current packet owner, meaningful while busy
//   busy          : arbiter is not in IDLE
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned DBIT    = DBIT_DEF,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DBIT-1:0]     req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DBIT-1:0]          tx_din,
  input  logic                     tx_done_tick,
  output logic [idx_w(NREQ)-1:0]   grant_id,
  output logic                     busy
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned TW = idx_w(TIMEOUT + 1);

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [DBIT-1:0] din_q, din_d;
  logic           start_q, start_d;
  logic           last_q, last_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [TW-1:0]  tmo_inc;

  logic [IW-1:0]  pick_idx;
  logic           pick_any;

  logic [DBIT-1:0] data_arr [NREQ];

  // Unflatten the request data bus
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DBIT +: DBIT];
  end

  // Next owner candidate, searched from the slot after the previous owner
  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (owner_q),
    .winner    (pick_idx),
    .any_valid (pick_any)
  );

  // Saturating stall counter increment
  always_comb begin
    tmo_inc = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= IW'(NREQ - 1);
      din_q   <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      din_q   <= din_d;
      start_q <= start_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state and accept logic
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    din_d     = din_q;
    start_d   = 1'b0;
    last_d    = last_q;
    tmo_d     = tmo_q;
    req_ready = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          tmo_d   = '0;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        req_ready[grant_q] = 1'b1;
        if (req_valid[grant_q]) begin
          din_d   = data_arr[grant_q];
          last_d  = req_last[grant_q];
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (tmo_inc == TW'(TIMEOUT)) begin
          // Owner stalled too long: drop the lock and pass priority on
          owner_d = grant_q;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_WAIT_DONE: begin
        if (tx_done_tick) begin
          if (last_q) begin
            owner_d = grant_q;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_start = start_q;
  assign tx_din   = din_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the transmitter.
REQ-002 Parameter DBIT, default 8: data bits per byte.
REQ-003 Parameter TIMEOUT, default 1023: idle clk cycles in SEND before the packet lock is released.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NREQ  per-requester byte-available flag.
REQ-007 req_data  input  NREQ*DBIT  flattened bytes; requester i occupies bits [i*DBIT +: DBIT].
REQ-008 req_last  input  NREQ  marks the byte as the final byte of requester i's packet.
REQ-009 req_ready  output  NREQ  one-hot accept strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 tx_start  output  1  one-cycle pulse that launches the shared UART transmitter.
REQ-011 tx_din  output  DBIT  byte for the transmitter; stable from tx_start until tx_done_tick.
REQ-012 tx_done_tick  input  1  one-cycle pulse from the transmitter when the stop bit completes.
REQ-013 grant_id  output  $clog2(NREQ)  index of the current packet owner; valid while busy.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, SEND, WAIT_DONE.
REQ-016 IDLE: if any req_valid is high, register the round-robin winner into grant_id and go to SEND on the next edge; otherwise stay in IDLE.
REQ-017 Round-robin: search starts at (last_owner+1) mod NREQ, and the first requester with req_valid high wins.
REQ-018 SEND: req_ready[grant_id] is driven combinationally high; every other req_ready bit is 0.
REQ-019 SEND with req_valid[grant_id] high: at the edge, capture req_data slice into tx_din and req_last into last_reg, set tx_start high for exactly the next cycle, clear the timeout counter, and go to WAIT_DONE.
REQ-020 SEND with req_valid[grant_id] low: increment the timeout counter and stay in SEND; other requesters stay blocked while the packet lock is held.
REQ-021 When the timeout counter reaches TIMEOUT: update last_owner to grant_id and go to IDLE; no byte is sent.
REQ-022 WAIT_DONE with tx_done_tick high and last_reg=1: update last_owner to grant_id and go to IDLE.
REQ-023 WAIT_DONE with tx_done_tick high and last_reg=0: go to SEND with the same grant_id.
REQ-024 tx_done_tick is ignored in IDLE and SEND.
REQ-025 Latency: at least 1 cycle from req_valid to req_ready, and tx_start follows the accepted transfer by 1 cycle.
REQ-026 Exactly one tx_start pulse per accepted byte; no byte is dropped or duplicated.
REQ-027 The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates; it never wraps.
REQ-028 Round-robin pointer increment wraps modulo NREQ, including for non-power-of-2 NREQ.

Reset
REQ-029 reset drives the state to IDLE, and drives tx_start, tx_din, grant_id, last_reg and the timeout counter to 0.
REQ-030 reset sets last_owner to NREQ-1, so requester 0 has first priority.
REQ-031 While reset is high: req_ready=0 and busy=0.
REQ-032 A reset asserted mid-packet abandons the packet; the arbiter does not resume it after reset.

Structure
REQ-033 The state enum and default NREQ/DBIT constants reside in shared package uart_pkg.
REQ-034 The winner search is a combinational sub-module, rr_pick (inputs: request vector and pointer; outputs: winner index and any-valid flag).

Verification
REQ-035 Single packet: requester 2 sends 0x41,0x42 with last on 0x42, tx_done_tick 10 cycles after each tx_start -> tx_din 0x41 then 0x42, two tx_start pulses, then IDLE and busy=0.
REQ-036 Fairness: all four requesters hold single-byte packets after reset -> grants in order 0,1,2,3, and a re-request by 0 is granted only after 3.
REQ-037 Lock: requester 1 is mid-packet while requester 0 raises valid -> 0 is not granted until 1's byte with last completes.
REQ-038 Timeout: TIMEOUT=15, and requester 3 drops valid after its first non-last byte -> release after 15 stalled SEND cycles, no extra tx_start, and the next grant goes to requester 0.
REQ-039 Spurious tick: tx_done_tick pulsed in IDLE and in SEND -> no state change and no tx_start.
REQ-040 Reset mid-packet in WAIT_DONE -> all outputs are 0 on the next cycle, and requester 0 is granted first afterwards.
